// File: rtl/mux_7seg_disp.sv
// Multiplexed active-low 7-segment driver: scans DIGITS digits with a blank GAP cycle between visits.
// Define MUX_7SEG_LZB_EN to enable leading-zero blanking of digits above digit 0.
module mux_7seg_disp #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic                  MODE,
    input  logic [4*DIGITS-1:0]   DATA,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  e,
    output logic                  f,
    output logic                  g,
    output logic                  dp,
    output logic [DIGITS-1:0]     AN
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        GAP  = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              state, next_state;
    logic [IW-1:0]       idx, next_idx;
    logic [CW-1:0]       cnt, next_cnt;
    logic [4*DIGITS-1:0] data_q;
    logic                mode_q;

    logic [6:0]          seg_q, seg_nxt;
    logic                dp_q, dp_nxt;
    logic [DIGITS-1:0]   an_q, an_nxt;

    logic [3:0]          nib [DIGITS];
    logic [3:0]          cur_nib;
    logic [3:0]          glyph;
    logic                neg;
    logic                show;

    // abcdefg, 0 = segment lit
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= GAP;
            idx    <= '0;
            cnt    <= '0;
            data_q <= '0;
            mode_q <= 1'b0;
            seg_q  <= '1;
            dp_q   <= 1'b1;
            an_q   <= '1;
        end else begin
            state  <= next_state;
            idx    <= next_idx;
            cnt    <= next_cnt;
            seg_q  <= seg_nxt;
            dp_q   <= dp_nxt;
            an_q   <= an_nxt;
            if (LOAD) begin
                data_q <= DATA;
                mode_q <= MODE;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_cnt   = cnt;
        unique case (state)
            GAP: begin
                next_state = SCAN;
                next_cnt   = '0;
            end
            SCAN: begin
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    next_state = GAP;
                    next_cnt   = '0;
                    next_idx   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            nib[k] = data_q[4*k +: 4];
        end
    end

    assign cur_nib = nib[next_idx];

`ifdef MUX_7SEG_LZB_EN
    // lz[k] is set when digit k and every digit above it hold nibble 0
    logic [DIGITS-1:0] lz;

    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run   = run && (nib[k] == 4'h0);
            lz[k] = run;
        end
    end

    assign show = (next_state == SCAN) && !((next_idx != '0) && lz[next_idx]);
`else
    assign show = (next_state == SCAN);
`endif

    // Outputs are computed from the upcoming state so they change on the same edge as the FSM.
    always_comb begin
        neg     = mode_q && cur_nib[3];
        glyph   = neg ? (4'd0 - cur_nib) : cur_nib;
        seg_nxt = '1;
        dp_nxt  = 1'b1;
        an_nxt  = '1;
        if (show) begin
            an_nxt  = ~(DIGITS'(1) << next_idx);
            seg_nxt = decode(glyph);
            dp_nxt  = ~neg;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp = dp_q;
    assign AN = an_q;

endmodule
